// File: rtl/rs_age_if.sv
// rs_age port bundle: dispatch, CDB, recovery and issue signals.
// master drives dispatch/CDB/control; slave is the reservation station.
interface rs_age_if #(
   parameter int SIZE      = 16,
   parameter int DISP_N    = 3,
   parameter int CDB_N     = 3,
   parameter int ISSUE_N   = 2,
   parameter int DATA_W    = 32,
   parameter int PRN_W     = 6,
   parameter int ROB_W     = 5,
   parameter int PAYLOAD_W = 32
);
   localparam int FS_W = $clog2(SIZE + 1);

   logic [DISP_N-1:0]                 disp_valid;
   logic [DISP_N-1:0]                 disp_ready;
   logic [DISP_N-1:0]                 disp_op1_ready;
   logic [DISP_N-1:0]                 disp_op2_ready;
   logic [DISP_N-1:0][DATA_W-1:0]     disp_op1;
   logic [DISP_N-1:0][DATA_W-1:0]     disp_op2;
   logic [DISP_N-1:0][PRN_W-1:0]      disp_dest_prn;
   logic [DISP_N-1:0][ROB_W-1:0]      disp_robn;
   logic [DISP_N-1:0][PAYLOAD_W-1:0]  disp_payload;

   logic [CDB_N-1:0]                  cdb_valid;
   logic [CDB_N-1:0][PRN_W-1:0]       cdb_prn;
   logic [CDB_N-1:0][DATA_W-1:0]      cdb_value;

   logic [ROB_W-1:0]                  rob_head;
   logic                              squash_valid;
   logic [ROB_W-1:0]                  squash_robn;
   logic                              flush;

   logic [ISSUE_N-1:0]                fu_avail;
   logic [ISSUE_N-1:0]                issue_valid;
   logic [ISSUE_N-1:0][DATA_W-1:0]    issue_op1;
   logic [ISSUE_N-1:0][DATA_W-1:0]    issue_op2;
   logic [ISSUE_N-1:0][PRN_W-1:0]     issue_dest_prn;
   logic [ISSUE_N-1:0][ROB_W-1:0]     issue_robn;
   logic [ISSUE_N-1:0][PAYLOAD_W-1:0] issue_payload;
   logic [FS_W-1:0]                   free_slots;

   modport master (
      output disp_valid, disp_op1_ready, disp_op2_ready,
      output disp_op1, disp_op2, disp_dest_prn, disp_robn, disp_payload,
      output cdb_valid, cdb_prn, cdb_value,
      output rob_head, squash_valid, squash_robn, flush, fu_avail,
      input  disp_ready, issue_valid, issue_op1, issue_op2,
      input  issue_dest_prn, issue_robn, issue_payload, free_slots
   );

   modport slave (
      input  disp_valid, disp_op1_ready, disp_op2_ready,
      input  disp_op1, disp_op2, disp_dest_prn, disp_robn, disp_payload,
      input  cdb_valid, cdb_prn, cdb_value,
      input  rob_head, squash_valid, squash_robn, flush, fu_avail,
      output disp_ready, issue_valid, issue_op1, issue_op2,
      output issue_dest_prn, issue_robn, issue_payload, free_slots
   );
endinterface

// File: rtl/rs_age.sv
// Oldest-first reservation station: CDB wakeup, age-ordered select,
// squash/flush recovery and registered issue ports.
module rs_age #(
   parameter int SIZE      = 16,
   parameter int DISP_N    = 3,
   parameter int CDB_N     = 3,
   parameter int ISSUE_N   = 2,
   parameter int DATA_W    = 32,
   parameter int PRN_W     = 6,
   parameter int ROB_W     = 5,
   parameter int PAYLOAD_W = 32
) (
   input logic   clock,
   input logic   reset,
   rs_age_if.slave bus
);
   localparam int FS_W = $clog2(SIZE + 1);
   localparam int IX_W = $clog2(SIZE);

   typedef struct packed {
      logic                 v;
      logic                 r1;
      logic                 r2;
      logic [DATA_W-1:0]    op1;
      logic [DATA_W-1:0]    op2;
      logic [PRN_W-1:0]     dst;
      logic [ROB_W-1:0]     robn;
      logic [PAYLOAD_W-1:0] pay;
   } ent_t;

   ent_t ent [SIZE];
   ent_t nxt [SIZE];

   logic [ROB_W-1:0]   ag [SIZE];
   logic [ROB_W-1:0]   sq_age;
   logic [SIZE-1:0]    kill_e;
   logic [SIZE-1:0]    rdy;
   logic [SIZE-1:0]    taken;
   logic [DISP_N-1:0]  acc;
   logic [DISP_N-1:0]  kill_l;
   logic [DISP_N-1:0]  drdy;
   logic [ISSUE_N-1:0] sel_v;
   logic [IX_W-1:0]    sel_i [ISSUE_N];
   logic [FS_W-1:0]    free_q;
   logic [FS_W-1:0]    free_d;

   logic [CDB_N-1:0]             cv;
   logic [CDB_N-1:0][PRN_W-1:0]  cp;
   logic [CDB_N-1:0][DATA_W-1:0] cd;

   logic [ISSUE_N-1:0]                iv_q;
   logic [ISSUE_N-1:0][DATA_W-1:0]    io1_q;
   logic [ISSUE_N-1:0][DATA_W-1:0]    io2_q;
   logic [ISSUE_N-1:0][PRN_W-1:0]     idst_q;
   logic [ISSUE_N-1:0][ROB_W-1:0]     irob_q;
   logic [ISSUE_N-1:0][PAYLOAD_W-1:0] ipay_q;

   assign cv = bus.cdb_valid;
   assign cp = bus.cdb_prn;
   assign cd = bus.cdb_value;

   // Returns {ready, value}; lowest-index matching CDB lane wins.
   function automatic logic [DATA_W:0] wake(
      input logic              r,
      input logic [DATA_W-1:0] val
   );
      logic [DATA_W:0] res;
      res = {r, val};
      for (int c = CDB_N - 1; c >= 0; c--) begin
         if (!r && cv[c] && cp[c] == val[PRN_W-1:0])
            res = {1'b1, cd[c]};
      end
      return res;
   endfunction

   always_comb begin
      sq_age = bus.squash_robn - bus.rob_head;
      for (int i = 0; i < SIZE; i++) begin
         ag[i]     = ent[i].robn - bus.rob_head;
         kill_e[i] = bus.flush | (bus.squash_valid & (ag[i] > sq_age));
         rdy[i]    = ent[i].v & ent[i].r1 & ent[i].r2 & ~kill_e[i];
      end
      for (int k = 0; k < DISP_N; k++) begin
         kill_l[k] = bus.flush | (bus.squash_valid &
                     (ROB_W'(bus.disp_robn[k] - bus.rob_head) > sq_age));
         drdy[k]   = free_q > FS_W'(k);
         acc[k]    = bus.disp_valid[k] & drdy[k];
      end
   end

   assign bus.disp_ready = drdy;

   // Each available port takes the oldest ready entry not yet taken.
   always_comb begin
      taken = '0;
      for (int p = 0; p < ISSUE_N; p++) begin
         sel_v[p] = 1'b0;
         sel_i[p] = '0;
         if (bus.fu_avail[p]) begin
            for (int i = 0; i < SIZE; i++) begin
               if (rdy[i] && !taken[i] &&
                   (!sel_v[p] || ag[i] < ag[sel_i[p]])) begin
                  sel_v[p] = 1'b1;
                  sel_i[p] = IX_W'(i);
               end
            end
         end
         if (sel_v[p])
            taken[sel_i[p]] = 1'b1;
      end
   end

   // Free slot of rank k receives dispatch lane k.
   always_comb begin
      logic [FS_W-1:0] rank;
      logic [DATA_W:0] w1;
      logic [DATA_W:0] w2;
      rank = '0;
      w1   = '0;
      w2   = '0;
      for (int i = 0; i < SIZE; i++) begin
         nxt[i] = ent[i];
         if (ent[i].v) begin
            w1 = wake(ent[i].r1, ent[i].op1);
            w2 = wake(ent[i].r2, ent[i].op2);
            nxt[i].r1  = w1[DATA_W];
            nxt[i].op1 = w1[DATA_W-1:0];
            nxt[i].r2  = w2[DATA_W];
            nxt[i].op2 = w2[DATA_W-1:0];
            if (kill_e[i] || taken[i])
               nxt[i].v = 1'b0;
         end else begin
            for (int k = 0; k < DISP_N; k++) begin
               if (acc[k] && rank == FS_W'(k)) begin
                  w1 = wake(bus.disp_op1_ready[k], bus.disp_op1[k]);
                  w2 = wake(bus.disp_op2_ready[k], bus.disp_op2[k]);
                  nxt[i].v    = ~kill_l[k];
                  nxt[i].r1   = w1[DATA_W];
                  nxt[i].op1  = w1[DATA_W-1:0];
                  nxt[i].r2   = w2[DATA_W];
                  nxt[i].op2  = w2[DATA_W-1:0];
                  nxt[i].dst  = bus.disp_dest_prn[k];
                  nxt[i].robn = bus.disp_robn[k];
                  nxt[i].pay  = bus.disp_payload[k];
               end
            end
            rank = rank + FS_W'(1);
         end
      end
   end

   always_comb begin
      free_d = FS_W'(SIZE);
      for (int i = 0; i < SIZE; i++)
         free_d = free_d - FS_W'(nxt[i].v);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SIZE; i++)
            ent[i] <= '0;
         free_q <= FS_W'(SIZE);
         iv_q   <= '0;
         io1_q  <= '0;
         io2_q  <= '0;
         idst_q <= '0;
         irob_q <= '0;
         ipay_q <= '0;
      end else begin
         for (int i = 0; i < SIZE; i++)
            ent[i] <= nxt[i];
         free_q <= free_d;
         for (int p = 0; p < ISSUE_N; p++) begin
            iv_q[p] <= sel_v[p];
            if (sel_v[p]) begin
               io1_q[p]  <= ent[sel_i[p]].op1;
               io2_q[p]  <= ent[sel_i[p]].op2;
               idst_q[p] <= ent[sel_i[p]].dst;
               irob_q[p] <= ent[sel_i[p]].robn;
               ipay_q[p] <= ent[sel_i[p]].pay;
            end
         end
      end
   end

   assign bus.issue_valid    = iv_q;
   assign bus.issue_op1      = io1_q;
   assign bus.issue_op2      = io2_q;
   assign bus.issue_dest_prn = idst_q;
   assign bus.issue_robn     = irob_q;
   assign bus.issue_payload  = ipay_q;
   assign bus.free_slots     = free_q;
endmodule

// File: tb/tb_rs_age.sv
// Directed bench for rs_age with an issue scoreboard.
// Expected issues are queued at dispatch and popped as ports fire.
module tb_rs_age;
   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   rs_age_if bus ();

   rs_age dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          port;
      logic [4:0]  robn;
      logic [31:0] op1;
      logic [31:0] op2;
   } exp_t;

   exp_t sb [$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic push(input int port, input logic [4:0] robn,
                       input logic [31:0] o1, input logic [31:0] o2);
      exp_t e;
      e.port = port;
      e.robn = robn;
      e.op1  = o1;
      e.op2  = o2;
      sb.push_back(e);
   endtask

   task automatic mon();
      exp_t e;
      for (int p = 0; p < 2; p++) begin
         if (bus.issue_valid[p] === 1'b1) begin
            chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("iss_port", 64'(p), 64'(e.port));
               chk("iss_robn", 64'(bus.issue_robn[p]), 64'(e.robn));
               chk("iss_op1", 64'(bus.issue_op1[p]), 64'(e.op1));
               chk("iss_op2", 64'(bus.issue_op2[p]), 64'(e.op2));
               chk("iss_dst", 64'(bus.issue_dest_prn[p]), 64'(e.robn));
               chk("iss_pay", 64'(bus.issue_payload[p]),
                   64'(32'hA000 | 32'(e.robn)));
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      mon();
   endtask

   task automatic idle();
      bus.disp_valid     = '0;
      bus.disp_op1_ready = '0;
      bus.disp_op2_ready = '0;
      bus.disp_op1       = '0;
      bus.disp_op2       = '0;
      bus.disp_dest_prn  = '0;
      bus.disp_robn      = '0;
      bus.disp_payload   = '0;
      bus.cdb_valid      = '0;
      bus.cdb_prn        = '0;
      bus.cdb_value      = '0;
      bus.squash_valid   = 1'b0;
      bus.squash_robn    = '0;
      bus.flush          = 1'b0;
   endtask

   task automatic set_lane(input int k, input logic r1,
                           input logic [31:0] o1, input logic r2,
                           input logic [31:0] o2, input logic [4:0] robn);
      bus.disp_valid[k]     = 1'b1;
      bus.disp_op1_ready[k] = r1;
      bus.disp_op1[k]       = o1;
      bus.disp_op2_ready[k] = r2;
      bus.disp_op2[k]       = o2;
      bus.disp_dest_prn[k]  = 6'(robn);
      bus.disp_robn[k]      = robn;
      bus.disp_payload[k]   = 32'hA000 | 32'(robn);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      idle();
      bus.rob_head = '0;
      bus.fu_avail = 2'b11;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      chk("rst_iv", 64'(bus.issue_valid), 64'd0);
      chk("rst_free", 64'(bus.free_slots), 64'd16);
      chk("rst_drdy", 64'(bus.disp_ready), 64'h7);
      chk("rst_op1", 64'(bus.issue_op1[0]), 64'd0);

      // three ready ops, oldest two issue together
      set_lane(0, 1'b1, 32'd102, 1'b1, 32'd202, 5'd2);
      set_lane(1, 1'b1, 32'd103, 1'b1, 32'd203, 5'd3);
      set_lane(2, 1'b1, 32'd104, 1'b1, 32'd204, 5'd4);
      push(0, 5'd2, 32'd102, 32'd202);
      push(1, 5'd3, 32'd103, 32'd203);
      push(0, 5'd4, 32'd104, 32'd204);
      tick();
      idle();
      chk("s1_iv_t1", 64'(bus.issue_valid), 64'd0);
      chk("s1_free_t1", 64'(bus.free_slots), 64'd13);
      tick();
      chk("s1_iv_t2", 64'(bus.issue_valid), 64'h3);
      chk("s1_free_t2", 64'(bus.free_slots), 64'd15);
      tick();
      chk("s1_iv_t3", 64'(bus.issue_valid), 64'h1);
      chk("s1_free_t3", 64'(bus.free_slots), 64'd16);
      tick();
      chk("s1_iv_t4", 64'(bus.issue_valid), 64'd0);

      // fill all 16 waiting on prn 5
      for (int r = 0; r < 16; r += 3) begin
         for (int k = 0; k < 3; k++)
            if (r + k < 16)
               set_lane(k, 1'b0, 32'd5, 1'b1, 32'h1000 + 32'(r + k),
                        5'(r + k));
         tick();
         idle();
      end
      chk("full_free", 64'(bus.free_slots), 64'd0);
      chk("full_drdy", 64'(bus.disp_ready), 64'd0);
      set_lane(0, 1'b1, 32'h1, 1'b1, 32'h2, 5'd20);
      tick();
      idle();
      chk("full_rej_free", 64'(bus.free_slots), 64'd0);
      chk("full_rej_iv", 64'(bus.issue_valid), 64'd0);
      for (int r = 0; r < 16; r++)
         push(r % 2, 5'(r), 32'hDEAD, 32'h1000 + 32'(r));
      bus.cdb_valid[0] = 1'b1;
      bus.cdb_prn[0]   = 6'd5;
      bus.cdb_value[0] = 32'hDEAD;
      tick();
      idle();
      chk("cdb_nobypass", 64'(bus.issue_valid), 64'd0);
      tick();
      chk("cdb_iv", 64'(bus.issue_valid), 64'h3);
      chk("cdb_free", 64'(bus.free_slots), 64'd2);
      repeat (7) tick();
      chk("drain_free", 64'(bus.free_slots), 64'd16);
      tick();
      chk("drain_iv", 64'(bus.issue_valid), 64'd0);

      // ROB wrap: 31 is older than 1 when head is 30
      bus.rob_head = 5'd30;
      bus.fu_avail = 2'b01;
      set_lane(0, 1'b1, 32'h11, 1'b1, 32'h12, 5'd1);
      set_lane(1, 1'b1, 32'h31, 1'b1, 32'h32, 5'd31);
      push(0, 5'd31, 32'h31, 32'h32);
      push(0, 5'd1, 32'h11, 32'h12);
      tick();
      idle();
      chk("wrap_iv_t1", 64'(bus.issue_valid), 64'd0);
      tick();
      chk("wrap_iv_t2", 64'(bus.issue_valid), 64'h1);
      tick();
      chk("wrap_iv_t3", 64'(bus.issue_valid), 64'h1);
      tick();
      chk("wrap_iv_t4", 64'(bus.issue_valid), 64'd0);
      chk("wrap_free", 64'(bus.free_slots), 64'd16);
      bus.rob_head = '0;
      bus.fu_avail = 2'b11;

      // squash younger than 3, then flush
      set_lane(0, 1'b0, 32'd9, 1'b1, 32'h2, 5'd2);
      set_lane(1, 1'b0, 32'd9, 1'b1, 32'h4, 5'd4);
      set_lane(2, 1'b0, 32'd9, 1'b1, 32'h6, 5'd6);
      tick();
      idle();
      chk("sq_free_pre", 64'(bus.free_slots), 64'd13);
      bus.squash_valid = 1'b1;
      bus.squash_robn  = 5'd3;
      set_lane(0, 1'b1, 32'h77, 1'b1, 32'h78, 5'd7);
      tick();
      idle();
      chk("sq_free", 64'(bus.free_slots), 64'd15);
      chk("sq_iv", 64'(bus.issue_valid), 64'd0);
      bus.flush = 1'b1;
      tick();
      idle();
      chk("fl_free", 64'(bus.free_slots), 64'd16);
      chk("fl_iv", 64'(bus.issue_valid), 64'd0);
      bus.cdb_valid[0] = 1'b1;
      bus.cdb_prn[0]   = 6'd9;
      bus.cdb_value[0] = 32'h99;
      tick();
      idle();
      tick();
      chk("fl_gone_iv", 64'(bus.issue_valid), 64'd0);

      // dispatch-time op2 capture, only port 1 free
      bus.fu_avail = 2'b10;
      set_lane(0, 1'b1, 32'h11, 1'b0, 32'd12, 5'd8);
      bus.cdb_valid    = 3'b111;
      bus.cdb_prn[0]   = 6'd13;
      bus.cdb_value[0] = 32'h9999;
      bus.cdb_prn[1]   = 6'd12;
      bus.cdb_value[1] = 32'hBEEF;
      bus.cdb_prn[2]   = 6'd12;
      bus.cdb_value[2] = 32'h5555;
      push(1, 5'd8, 32'h11, 32'hBEEF);
      tick();
      idle();
      chk("dcap_iv_t1", 64'(bus.issue_valid), 64'd0);
      tick();
      chk("dcap_iv_t2", 64'(bus.issue_valid), 64'h2);
      tick();
      chk("dcap_iv_t3", 64'(bus.issue_valid), 64'd0);
      bus.fu_avail = 2'b11;

      // async reset while issue registers are loaded
      set_lane(0, 1'b1, 32'hA, 1'b1, 32'hB, 5'd10);
      set_lane(1, 1'b1, 32'hC, 1'b1, 32'hD, 5'd11);
      push(0, 5'd10, 32'hA, 32'hB);
      push(1, 5'd11, 32'hC, 32'hD);
      tick();
      idle();
      tick();
      chk("ar_iv_pre", 64'(bus.issue_valid), 64'h3);
      #2 reset = 1'b1;
      #1;
      chk("ar_iv", 64'(bus.issue_valid), 64'd0);
      chk("ar_free", 64'(bus.free_slots), 64'd16);
      chk("ar_op1", 64'(bus.issue_op1[0]), 64'd0);
      #1 reset = 1'b0;
      tick();
      chk("ar_iv_post", 64'(bus.issue_valid), 64'd0);
      chk("ar_free_post", 64'(bus.free_slots), 64'd16);

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
